// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: PC register, synchronous-read instruction memory and a
// prefetch queue of {PC, instruction} pairs presented to decode over valid/ready.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   redirect_i             branch/jump taken: flush queue and in-flight read, refetch
//   redirect_addr_i        redirect target byte address (low two bits ignored)
//   out_ready_i            decode accepts the head entry
//   out_valid_o            head entry valid
//   out_instr_o            head instruction
//   out_pc_o               byte address of head instruction
//   out_pc_plus4_o         out_pc_o + 4
//   write_enable_i         memory load strobe (suppresses fetch issue that cycle)
//   write_addr_i           byte address of the word to load
//   write_data_i           word to load
//   queue_count_o          occupied queue entries
module fetch_queue_stage #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       MEM_AW      = 8,
  parameter int unsigned       QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               redirect_i,
  input  logic [ADDR_W-1:0]                  redirect_addr_i,
  input  logic                               out_ready_i,
  output logic                               out_valid_o,
  output logic [DATA_W-1:0]                  out_instr_o,
  output logic [ADDR_W-1:0]                  out_pc_o,
  output logic [ADDR_W-1:0]                  out_pc_plus4_o,
  input  logic                               write_enable_i,
  input  logic [ADDR_W-1:0]                  write_addr_i,
  input  logic [DATA_W-1:0]                  write_data_i,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count_o
);

  localparam int unsigned CntW     = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PtrW     = $clog2(QUEUE_DEPTH);
  localparam int unsigned MemDepth = 2 ** MEM_AW;

  logic [DATA_W-1:0] mem [MemDepth];
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] cap_pc_q;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] pc_q    [QUEUE_DEPTH];
  logic [DATA_W-1:0] instr_q [QUEUE_DEPTH];

  logic [MEM_AW-1:0] fetch_idx, wr_idx;
  logic [31:0]       occupancy;
  logic              issue, enq, deq;

  // Only the word-index bits of the byte addresses matter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{write_addr_i, redirect_addr_i[1:0]};

  assign fetch_idx = fetch_pc_q[MEM_AW+1:2];
  assign wr_idx    = write_addr_i[MEM_AW+1:2];

  // The in-flight read reserves a slot, so the queue can never overflow; a dequeue in
  // the same cycle deliberately earns no credit to keep this path short.
  assign occupancy = 32'(count_q) + 32'(inflight_q);
  assign issue     = !redirect_i && !write_enable_i && (occupancy < QUEUE_DEPTH);
  assign enq       = inflight_q && !redirect_i;
  assign deq       = out_valid_o && out_ready_i;

  // Memory contents are not reset; a write and an issue never share a cycle.
  always_ff @(posedge clk_i) begin
    if (write_enable_i) begin
      mem[wr_idx] <= write_data_i;
    end
    if (issue) begin
      rdata_q  <= mem[fetch_idx];
      cap_pc_q <= fetch_pc_q;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = issue;
    if (redirect_i) begin
      fetch_pc_d = {redirect_addr_i[ADDR_W-1:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (enq && !deq) begin
        count_d = count_q + CntW'(1);
      end else if (!enq && deq) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
      if (enq) begin
        pc_q[wr_ptr_q]    <= cap_pc_q;
        instr_q[wr_ptr_q] <= rdata_q;
      end
    end
  end

  assign out_valid_o    = (count_q != '0);
  assign out_instr_o    = instr_q[rd_ptr_q];
  assign out_pc_o       = pc_q[rd_ptr_q];
  assign out_pc_plus4_o = out_pc_o + ADDR_W'(4);
  assign queue_count_o  = count_q;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: expected {PC, instr} pairs are queued as
// stimulus is set up and popped when decode completes a handshake.
module tb_fetch_queue_stage;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        out_ready = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] write_addr = '0;
  logic [31:0] write_data = '0;

  logic        out_valid, o2_valid;
  logic [31:0] out_instr, out_pc, out_pc4, o2_instr, o2_pc, o2_pc4;
  logic [2:0]  queue_count, o2_count;

  always #5 clk = ~clk;

  fetch_queue_stage dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .out_ready_i    (out_ready),
    .out_valid_o    (out_valid),
    .out_instr_o    (out_instr),
    .out_pc_o       (out_pc),
    .out_pc_plus4_o (out_pc4),
    .write_enable_i (write_enable),
    .write_addr_i   (write_addr),
    .write_data_i   (write_data),
    .queue_count_o  (queue_count)
  );

  // Second instance starting near the top of memory to exercise index wrap.
  fetch_queue_stage #(.RESET_PC(32'h0000_03FC)) dut_wrap (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .out_ready_i    (out_ready),
    .out_valid_o    (o2_valid),
    .out_instr_o    (o2_instr),
    .out_pc_o       (o2_pc),
    .out_pc_plus4_o (o2_pc4),
    .write_enable_i (write_enable),
    .write_addr_i   (write_addr),
    .write_data_i   (write_data),
    .queue_count_o  (o2_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_m [256];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      sb_q.push_back('{pc: pc, instr: mem_m[pc[9:2]]});
    end
  endtask

  task automatic wait_drain(input string tag, input int bound);
    for (int i = 0; i < bound && sb_q.size() != 0; i++) step(1);
    check_eq({"drain_", tag}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic do_redirect(input logic [31:0] addr, input logic [31:0] exp_pc, input int n);
    redirect      = 1'b1;
    redirect_addr = addr;
    step(1);
    redirect = 1'b0;
    check_eq("redir_count", 64'(queue_count), 64'd0);
    check_eq("redir_valid_a", 64'(out_valid), 64'd0);
    sb_q.delete();
    push_seq(exp_pc, n);
    step(1);
    check_eq("redir_valid_b", 64'(out_valid), 64'd0);
    step(1);
    check_eq("redir_valid_c", 64'(out_valid), 64'd1);
    wait_drain("redir", 10);
  endtask

  // Monitor: outputs sampled on the falling edge, handshake completes on the next rise.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      check_eq("count_bound", 64'(queue_count <= 3'(Depth)), 64'd1);
      if (out_valid && out_ready && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("out_pc", 64'(out_pc), 64'(e.pc));
        check_eq("out_instr", 64'(out_instr), 64'(e.instr));
        check_eq("out_pc4", 64'(out_pc4), 64'(e.pc + 32'd4));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #1 rst_n = 1'b0;
    // Load memory while held in reset.
    for (int i = 0; i < 256; i++) begin
      mem_m[i]     = 32'h1000_0000 + 32'(i) * 32'h0003_0007;
      write_enable = 1'b1;
      write_addr   = 32'(i) << 2;
      write_data   = mem_m[i];
      step(1);
    end
    write_enable = 1'b0;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_instr", 64'(out_instr), 64'd0);
    check_eq("rst_pc", 64'(out_pc), 64'd0);
    check_eq("rst_count", 64'(queue_count), 64'd0);

    // Sequential fetch with decode always ready.
    out_ready = 1'b1;
    push_seq(32'h0, 4);
    rst_n = 1'b1;
    step(1);
    check_eq("start_valid_1", 64'(out_valid), 64'd0);
    step(1);
    check_eq("start_valid_2", 64'(out_valid), 64'd1);
    check_eq("wrap_pc_0", 64'(o2_pc), 64'h3FC);
    check_eq("wrap_instr_0", 64'(o2_instr), 64'(mem_m[255]));
    step(1);
    check_eq("wrap_pc_1", 64'(o2_pc), 64'h400);
    check_eq("wrap_instr_1", 64'(o2_instr), 64'(mem_m[0]));
    step(1);
    check_eq("wrap_pc_2", 64'(o2_pc), 64'h404);
    check_eq("wrap_instr_2", 64'(o2_instr), 64'(mem_m[1]));
    wait_drain("seq", 10);

    // Backpressure from reset release.
    rst_n     = 1'b0;
    out_ready = 1'b0;
    sb_q.delete();
    push_seq(32'h0, 5);
    step(1);
    rst_n = 1'b1;
    step(8);
    check_eq("bp_count", 64'(queue_count), 64'd4);
    check_eq("bp_valid", 64'(out_valid), 64'd1);
    check_eq("bp_head_pc", 64'(out_pc), 64'd0);
    check_eq("bp_head_instr", 64'(out_instr), 64'(mem_m[0]));
    out_ready = 1'b1;
    wait_drain("bp", 12);

    // Redirects while streaming.
    do_redirect(32'h38, 32'h38, 2);
    do_redirect(32'h3A, 32'h38, 2);
    do_redirect(32'h3FC, 32'h3FC, 3);

    // Memory load: write at the first edge delays issue; a write behind an in-flight
    // read leaves that read with the old word.
    rst_n     = 1'b0;
    out_ready = 1'b0;
    sb_q.delete();
    step(1);
    rst_n        = 1'b1;
    write_enable = 1'b1;
    write_addr   = 32'h8;
    write_data   = 32'hDEAD_BEEF;
    mem_m[2]     = 32'hDEAD_BEEF;
    step(1);
    write_enable = 1'b0;
    step(1);
    check_eq("wr_no_issue", 64'(out_valid), 64'd0);
    step(1);
    check_eq("wr_valid", 64'(out_valid), 64'd1);
    step(2);
    push_seq(32'h0, 4);
    write_enable = 1'b1;
    write_addr   = 32'hC;
    write_data   = 32'hFEED_F00D;
    mem_m[3]     = 32'hFEED_F00D;
    step(1);
    write_enable = 1'b0;
    push_seq(32'h10, 1);
    step(2);
    check_eq("wr_full_count", 64'(queue_count), 64'd4);
    out_ready = 1'b1;
    wait_drain("wr", 12);
    do_redirect(32'hC, 32'hC, 2);

    // Asynchronous reset between edges with three entries queued.
    rst_n     = 1'b0;
    out_ready = 1'b0;
    sb_q.delete();
    step(1);
    rst_n = 1'b1;
    step(4);
    check_eq("ar_count_before", 64'(queue_count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_valid", 64'(out_valid), 64'd0);
    check_eq("ar_count", 64'(queue_count), 64'd0);
    step(1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    push_seq(32'h0, 3);
    wait_drain("ar", 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
